// File: rtl/wt_mem_responder.sv
// Fixed-latency memory responder for the write-through cache req/rtrn protocol.
// Requests are queued in order and answered from a line-organised scratchpad.
module wt_mem_responder #(
    parameter int MemLines   = 1024,
    parameter int LineWidth  = 128,
    parameter int DataWidth  = 64,
    parameter int PaddrWidth = 32,
    parameter int TidWidth   = 2,
    parameter int QueueDepth = 4,
    parameter int Latency    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_data_req_i,
    output logic                  mem_data_ack_o,
    input  logic [1:0]            mem_data_rtype_i,
    input  logic [2:0]            mem_data_size_i,
    input  logic [TidWidth-1:0]   mem_data_tid_i,
    input  logic [PaddrWidth-1:0] mem_data_paddr_i,
    input  logic [DataWidth-1:0]  mem_data_data_i,
    output logic                  mem_rtrn_vld_o,
    output logic [1:0]            mem_rtrn_rtype_o,
    output logic [TidWidth-1:0]   mem_rtrn_tid_o,
    output logic [LineWidth-1:0]  mem_rtrn_data_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int OffW  = $clog2(LineWidth / 8);
    localparam int IdxW  = $clog2(MemLines);
    localparam int BeW   = DataWidth / 8;
    localparam int LaneW = $clog2(BeW);
    localparam int WordW = OffW - LaneW;
    localparam int PtrW  = $clog2(QueueDepth);
    localparam int CntW  = (Latency > 1) ? $clog2(Latency) : 1;

    typedef enum logic {IDLE, WAIT} state_e;

    typedef struct packed {
        logic [1:0]            rtype;
        logic [2:0]            size;
        logic [TidWidth-1:0]   tid;
        logic [PaddrWidth-1:0] paddr;
        logic [DataWidth-1:0]  data;
    } req_t;

    req_t                 fifo_q [QueueDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q, count_d;
    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 err_q;
    logic [LineWidth-1:0] mem_q [MemLines];

    logic                 full, push, exec;
    req_t                 head;
    logic                 is_load, is_store, type_ok, size_ok, align_ok, req_err, mem_we;
    logic [LaneW:0]       nbytes;
    logic [BeW-1:0]       be_base, be;
    logic [IdxW-1:0]      idx;
    logic [WordW-1:0]     word;
    logic [LineWidth-1:0] rd_line, wr_line;
    logic                 unused_paddr_bits;

    assign full           = (count_q == (PtrW + 1)'(QueueDepth));
    assign push           = mem_data_req_i & ~full;
    assign mem_data_ack_o = push;

    assign head = fifo_q[rd_ptr_q];
    assign exec = (state_q == WAIT) && (cnt_q == '0);

    assign is_load  = (head.rtype == 2'd0);
    assign is_store = (head.rtype == 2'd1);
    assign type_ok  = is_load | is_store;
    assign size_ok  = (head.size <= 3'(LaneW));
    assign nbytes   = (LaneW + 1)'(1) << head.size;
    assign align_ok = (head.paddr[LaneW-1:0] & LaneW'(nbytes - (LaneW + 1)'(1))) == '0;
    assign req_err  = ~type_ok | ~size_ok | ~align_ok;
    assign mem_we   = exec & is_store & size_ok & align_ok;

    // Byte enables only matter for aligned stores, which never spill past the last lane.
    assign be_base = BeW'(((BeW + 1)'(1) << nbytes) - (BeW + 1)'(1));
    assign be      = be_base << head.paddr[LaneW-1:0];

    assign idx     = head.paddr[OffW +: IdxW];
    assign word    = head.paddr[LaneW +: WordW];
    assign rd_line = mem_q[idx];

    assign unused_paddr_bits = ^head.paddr[PaddrWidth-1:OffW+IdxW];

    always_comb begin
        wr_line = rd_line;
        for (int k = 0; k < BeW; k++) begin
            if (be[k]) begin
                wr_line[(int'(word) * BeW + k) * 8 +: 8] = head.data[k * 8 +: 8];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !exec) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (!push && exec) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    // NOTE: FIFO payload and scratchpad have no reset so they map onto plain RAM;
    // only pointers and control state need a known value.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{rtype: mem_data_rtype_i, size: mem_data_size_i,
                                  tid: mem_data_tid_i, paddr: mem_data_paddr_i,
                                  data: mem_data_data_i};
        end
        if (mem_we) begin
            mem_q[idx] <= wr_line;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (exec) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            if (exec && req_err) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        cnt_q   <= CntW'(Latency - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
                    else             state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Returns are decoded from the execute state so they appear in the execute cycle itself.
    assign mem_rtrn_vld_o   = exec & type_ok;
    assign mem_rtrn_rtype_o = mem_rtrn_vld_o ? head.rtype : 2'd0;
    assign mem_rtrn_tid_o   = mem_rtrn_vld_o ? head.tid : '0;
    assign mem_rtrn_data_o  = (exec && is_load) ? rd_line : '0;
    assign err_o            = err_q;
    assign busy_o           = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder: ordering, latency, byte stores, errors, reset.
module tb_wt_mem_responder;

    localparam logic [127:0] LINE4   = {64'hCAFEF00D12345678, 64'h11223344AB667788};
    localparam logic [127:0] LO_MASK = {64'h0, {64{1'b1}}};
    localparam logic [127:0] ALL     = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         req, ack;
    logic [1:0]   rtype;
    logic [2:0]   size;
    logic [1:0]   tid;
    logic [31:0]  paddr;
    logic [63:0]  wdata;
    logic         vld;
    logic [1:0]   r_rtype;
    logic [1:0]   r_tid;
    logic [127:0] r_data;
    logic         err, busy;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int           cyc;
        logic [1:0]   rtype;
        logic [1:0]   tid;
        logic [127:0] data;
    } rtrn_t;
    rtrn_t rq[$];

    wt_mem_responder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_data_req_i   (req),
        .mem_data_ack_o   (ack),
        .mem_data_rtype_i (rtype),
        .mem_data_size_i  (size),
        .mem_data_tid_i   (tid),
        .mem_data_paddr_i (paddr),
        .mem_data_data_i  (wdata),
        .mem_rtrn_vld_o   (vld),
        .mem_rtrn_rtype_o (r_rtype),
        .mem_rtrn_tid_o   (r_tid),
        .mem_rtrn_data_o  (r_data),
        .err_o            (err),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (vld) rq.push_back('{cyc, r_rtype, r_tid, r_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rt, input logic [2:0] sz, input logic [1:0] id,
                         input logic [31:0] pa, input logic [63:0] d);
        req = 1'b1; rtype = rt; size = sz; tid = id; paddr = pa; wdata = d;
    endtask

    task automatic send(input string tag, input logic [1:0] rt, input logic [2:0] sz,
                        input logic [1:0] id, input logic [31:0] pa, input logic [63:0] d,
                        output int acc);
        @(negedge clk);
        drive(rt, sz, id, pa, d);
        #1;
        check({tag, "_ack"}, ack, 1'b1);
        acc = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic expect_rtrn(input string tag, input int exp_cyc, input logic [1:0] exp_rt,
                               input logic [1:0] exp_tid, input logic [127:0] exp_data,
                               input logic [127:0] mask);
        int    guard = 0;
        rtrn_t r;
        while (rq.size() == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_present"}, 128'(rq.size() != 0), 1'b1);
        if (rq.size() != 0) begin
            r = rq.pop_front();
            check({tag, "_cyc"}, r.cyc, exp_cyc);
            check({tag, "_rtype"}, r.rtype, exp_rt);
            check({tag, "_tid"}, r.tid, exp_tid);
            check({tag, "_data"}, r.data & mask, exp_data & mask);
        end
    endtask

    initial begin
        int t, base, acc;
        logic [7:0] exp_ack;

        rst = 1'b1; req = 1'b0; rtype = '0; size = '0; tid = '0; paddr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_vld", vld, 1'b0);
        check("rst_rtype", r_rtype, 2'd0);
        check("rst_tid", r_tid, 2'd0);
        check("rst_data", r_data, 128'h0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Full-word store then load of the same line
        send("t1", 2'd1, 3'd3, 2'd1, 32'h40, 64'h1122334455667788, t);
        expect_rtrn("t1", t + 3, 2'd1, 2'd1, 128'h0, ALL);
        send("t2", 2'd0, 3'd3, 2'd2, 32'h40, 64'h0, t);
        expect_rtrn("t2", t + 3, 2'd0, 2'd2, {64'h0, 64'h1122334455667788}, LO_MASK);

        // Single-byte store touches only lane 3
        send("t3s", 2'd1, 3'd0, 2'd3, 32'h43, 64'hDEADBEEF_AB5A5A5A, t);
        expect_rtrn("t3s", t + 3, 2'd1, 2'd3, 128'h0, ALL);
        send("t3l", 2'd0, 3'd0, 2'd0, 32'h40, 64'h0, t);
        expect_rtrn("t3l", t + 3, 2'd0, 2'd0, {64'h0, 64'h11223344AB667788}, LO_MASK);
        check("t3_err", err, 1'b0);

        // Upper word of the line, read back through a wrapped address
        send("t3u", 2'd1, 3'd3, 2'd1, 32'h48, 64'hCAFEF00D12345678, t);
        expect_rtrn("t3u", t + 3, 2'd1, 2'd1, 128'h0, ALL);
        send("t3w", 2'd0, 3'd3, 2'd2, 32'h4040, 64'h0, t);
        expect_rtrn("t3w", t + 3, 2'd0, 2'd2, LINE4, ALL);

        // Six held loads: ack pattern 1,1,1,1,1,0,0,1 across eight cycles
        exp_ack = 8'b1001_1111;
        acc = 0;
        base = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) base = cyc;
            drive(2'd0, 3'd3, 2'(acc), 32'h40, 64'h0);
            #1;
            check($sformatf("t4_ack%0d", c), ack, exp_ack[c]);
            if (ack) acc++;
        end
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expect_rtrn($sformatf("t4_r%0d", k), base + 3 + 3 * k, 2'd0, 2'(k), LINE4, ALL);
        end

        // Misaligned store and unsupported rtype
        check("t5_err_pre", err, 1'b0);
        send("t5s", 2'd1, 3'd2, 2'd0, 32'h42, 64'hFFFFFFFF_FFFFFFFF, t);
        expect_rtrn("t5s", t + 3, 2'd1, 2'd0, 128'h0, ALL);
        @(negedge clk);
        check("t5_err", err, 1'b1);
        send("t5x", 2'd3, 3'd3, 2'd1, 32'h40, 64'h0, t);
        repeat (8) @(negedge clk);
        check("t5x_noret", rq.size(), 0);
        check("t5x_busy", busy, 1'b0);
        check("t5x_err", err, 1'b1);
        send("t5l", 2'd0, 3'd3, 2'd2, 32'h40, 64'h0, t);
        expect_rtrn("t5l", t + 3, 2'd0, 2'd2, LINE4, ALL);
        check("t5_err_sticky", err, 1'b1);

        // Reset with three requests queued behind one in flight
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) base = cyc;
            drive(2'd0, 3'd3, 2'(c), 32'h40, 64'h0);
            #1;
            check($sformatf("t6_ack%0d", c), ack, 1'b1);
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        check("t6_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_vld", vld, 1'b0);
        expect_rtrn("t6x", base + 3, 2'd0, 2'd0, LINE4, ALL);
        repeat (10) @(negedge clk);
        check("t6_noret", rq.size(), 0);
        send("t6l", 2'd0, 3'd3, 2'd3, 32'h40, 64'h0, t);
        expect_rtrn("t6l", t + 3, 2'd0, 2'd3, LINE4, ALL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
